// File: rtl/znz_split_issue.sv
// Splits one raw activation group into beats of at most GROUP_NZ_BITS non-zeros each.
// Latency 1 cycle accept->out_valid; next group is accepted only as the last beat drains.
module znz_split_issue #(
  parameter int GROUP_SIZE    = 32,
  parameter int GROUP_NZ_BITS = 16,
  parameter int DATA_W        = 8,
  parameter int CNT_W         = $clog2(GROUP_SIZE + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [GROUP_SIZE-1:0][DATA_W-1:0]  in_act,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [GROUP_SIZE-1:0]              out_znz,
  output logic [GROUP_SIZE-1:0][DATA_W-1:0]  out_act,
  output logic [CNT_W-1:0]                   out_nz_cnt,
  output logic                               out_first,
  output logic                               out_last
);

  typedef enum logic {EMPTY, ISSUE} state_e;

  localparam logic [CNT_W-1:0] NZ_MAX = CNT_W'(GROUP_NZ_BITS);

  state_e                            state_q, state_d;
  logic [GROUP_SIZE-1:0][DATA_W-1:0] act_q, act_d;
  logic [GROUP_SIZE-1:0]             rem_q, rem_d;
  logic                              first_q, first_d;

  logic [GROUP_SIZE-1:0] nz_map;
  logic [GROUP_SIZE-1:0] sel_znz;
  logic [CNT_W-1:0]      sel_cnt;
  logic                  accept;

  always_comb begin
    nz_map = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      nz_map[i] = |in_act[i];
    end
  end

  // Take remaining set bits lowest-index first until the beat is full.
  always_comb begin
    sel_znz = '0;
    sel_cnt = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (rem_q[i] && (sel_cnt < NZ_MAX)) begin
        sel_znz[i] = 1'b1;
        sel_cnt    = sel_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid  = (state_q == ISSUE);
  assign out_znz    = sel_znz;
  assign out_nz_cnt = sel_cnt;
  assign out_last   = ((rem_q & ~sel_znz) == '0);
  assign out_first  = first_q;
  assign out_act    = act_q;

  assign in_ready = !rst && (!out_valid || (out_ready && out_last));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    rem_d   = rem_q;
    first_d = first_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ISSUE;
          act_d   = in_act;
          rem_d   = nz_map;
          first_d = 1'b1;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          if (!out_last) begin
            rem_d   = rem_q & ~sel_znz;
            first_d = 1'b0;
          end else if (accept) begin
            act_d   = in_act;
            rem_d   = nz_map;
            first_d = 1'b1;
          end else begin
            state_d = EMPTY;
            rem_d   = '0;
            first_d = 1'b0;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      act_q   <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      rem_q   <= rem_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_znz_split_issue.sv
// Bench for znz_split_issue: expected beats are queued on accept and compared as beats are consumed.
module tb_znz_split_issue;

  localparam int GS = 32;
  localparam int NZ = 16;
  localparam int DW = 8;
  localparam int CW = 6;

  typedef logic [GS-1:0][DW-1:0] act_t;
  typedef struct {
    logic [GS-1:0] znz;
    logic [CW-1:0] cnt;
    logic          first;
    logic          last;
    act_t          act;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  act_t          in_act = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [GS-1:0] out_znz;
  act_t          out_act;
  logic [CW-1:0] out_nz_cnt;
  logic          out_first;
  logic          out_last;

  int    checks = 0;
  int    failures = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  znz_split_issue #(.GROUP_SIZE(GS), .GROUP_NZ_BITS(NZ), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_znz(out_znz), .out_act(out_act), .out_nz_cnt(out_nz_cnt),
    .out_first(out_first), .out_last(out_last)
  );

  // Reference split: beat b covers non-zeros with rank in [b*NZ, (b+1)*NZ).
  function automatic void push_expected(input act_t a);
    logic [GS-1:0] nzm;
    int k, nb, rank;
    beat_t bt;
    nzm = '0;
    k = 0;
    for (int i = 0; i < GS; i++) begin
      nzm[i] = (a[i] != '0);
      if (nzm[i]) k++;
    end
    nb = (k == 0) ? 1 : (k + NZ - 1) / NZ;
    for (int b = 0; b < nb; b++) begin
      bt.znz = '0;
      rank = 0;
      for (int i = 0; i < GS; i++) begin
        if (nzm[i]) begin
          if (rank >= b * NZ && rank < (b + 1) * NZ) bt.znz[i] = 1'b1;
          rank++;
        end
      end
      bt.cnt   = CW'((k == 0) ? 0 : ((b == nb - 1) ? k - b * NZ : NZ));
      bt.first = (b == 0);
      bt.last  = (b == nb - 1);
      bt.act   = a;
      sb.push_back(bt);
    end
  endfunction

  // Scoreboard monitor, sampled mid-low-phase after the driver has settled.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected got znz=%h", out_znz);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if (out_znz !== e.znz || out_nz_cnt !== e.cnt || out_first !== e.first ||
            out_last !== e.last || out_act !== e.act) begin
          failures++;
          $display("FAIL beat got znz=%h cnt=%0d first=%b last=%b want znz=%h cnt=%0d first=%b last=%b act_ok=%b",
                   out_znz, out_nz_cnt, out_first, out_last, e.znz, e.cnt, e.first, e.last, out_act === e.act);
        end
      end
    end
    if (!rst && in_valid && in_ready) push_expected(in_act);
  end

  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic send(input act_t a, output int waits);
    in_act   = a;
    in_valid = 1'b1;
    waits    = 0;
    #1;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (waits >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic act_t mk_act(input logic [GS-1:0] map);
    act_t a;
    for (int i = 0; i < GS; i++) a[i] = map[i] ? DW'(i + 1) : '0;
    return a;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    end
    checks++;
    if (out_znz !== '0 || out_nz_cnt !== '0 || out_last !== 1'b1 || out_first !== 1'b0 || out_act !== '0) begin
      failures++;
      $display("FAIL reset_out got znz=%h cnt=%0d last=%b first=%b want 0 0 1 0", out_znz, out_nz_cnt, out_last, out_first);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_sparse;
    int w;
    out_ready = 1'b1;
    send(mk_act(32'h8010_0089), w);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_znz !== 32'h8010_0089 || out_nz_cnt !== 6'd5 ||
        out_first !== 1'b1 || out_last !== 1'b1) begin
      failures++;
      $display("FAIL sparse got v=%b znz=%h cnt=%0d f=%b l=%b want 1 80100089 5 1 1",
               out_valid, out_znz, out_nz_cnt, out_first, out_last);
    end
    @(negedge clk);
  endtask

  task automatic test_dense;
    int w;
    out_ready = 1'b1;
    send(mk_act(32'hFFFF_FFFF), w);
    #1;
    checks++;
    if (out_znz !== 32'h0000_FFFF || out_nz_cnt !== 6'd16 || out_first !== 1'b1 ||
        out_last !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL dense_b1 got znz=%h cnt=%0d f=%b l=%b rdy=%b want 0000ffff 16 1 0 0",
               out_znz, out_nz_cnt, out_first, out_last, in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_znz !== 32'hFFFF_0000 || out_nz_cnt !== 6'd16 || out_first !== 1'b0 ||
        out_last !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL dense_b2 got znz=%h cnt=%0d f=%b l=%b rdy=%b want ffff0000 16 0 1 1",
               out_znz, out_nz_cnt, out_first, out_last, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_then_next;
    int w;
    out_ready = 1'b1;
    send('0, w);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_znz !== '0 || out_nz_cnt !== '0 || out_first !== 1'b1 || out_last !== 1'b1) begin
      failures++;
      $display("FAIL zero_beat got v=%b znz=%h cnt=%0d f=%b l=%b want 1 0 0 1 1",
               out_valid, out_znz, out_nz_cnt, out_first, out_last);
    end
    send(mk_act(32'h0000_0104), w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL zero_b2b waits=%0d want 0", w);
    end
    #1;
    checks++;
    if (out_znz !== 32'h0000_0104 || out_first !== 1'b1) begin
      failures++;
      $display("FAIL zero_next got znz=%h f=%b want 00000104 1", out_znz, out_first);
    end
    @(negedge clk);
  endtask

  task automatic test_seventeen;
    int w;
    out_ready = 1'b1;
    send(mk_act(32'h0001_FFFF), w);
    #1;
    checks++;
    if (out_znz !== 32'h0000_FFFF || out_nz_cnt !== 6'd16 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL n17_b1 got znz=%h cnt=%0d l=%b want 0000ffff 16 0", out_znz, out_nz_cnt, out_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_znz !== 32'h0001_0000 || out_nz_cnt !== 6'd1 || out_last !== 1'b1 || out_first !== 1'b0) begin
      failures++;
      $display("FAIL n17_b2 got znz=%h cnt=%0d l=%b f=%b want 00010000 1 1 0", out_znz, out_nz_cnt, out_last, out_first);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int w, bubbles;
    logic [GS-1:0] z;
    act_t a;
    out_ready = 1'b0;
    send(mk_act(32'hFFFF_FFFF), w);
    in_act   = mk_act(32'h0000_0001);
    in_valid = 1'b1;
    #1;
    z = out_znz;
    a = out_act;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_znz !== z || out_act !== a || out_first !== 1'b1 ||
          out_last !== 1'b0 || out_nz_cnt !== 6'd16 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_c%0d got v=%b znz=%h rdy=%b want 1 %h 0", c, out_valid, out_znz, in_ready, z);
      end
      @(negedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    bubbles = 0;
    for (int g = 0; g < 4; g++) begin
      send(mk_act(32'h0000_0011 << (g * 4)), w);
      if (w != 0) bubbles++;
      #1;
      if (out_valid !== 1'b1) bubbles++;
    end
    checks++;
    if (bubbles !== 0) begin
      failures++;
      $display("FAIL stream bubbles=%0d want 0", bubbles);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_split;
    int w;
    out_ready = 1'b1;
    send(mk_act(32'hFFFF_FFFF), w);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid out_valid=%b want 0", out_valid);
    end
    sb.delete();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_quiet out_valid=%b want 0", out_valid);
    end
    send(mk_act(32'h0000_8002), w);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_first !== 1'b1 || out_znz !== 32'h0000_8002) begin
      failures++;
      $display("FAIL rst_mid_after got v=%b f=%b znz=%h want 1 1 00008002", out_valid, out_first, out_znz);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    bit done;
    done = 1'b0;
    fork
      begin
        int w;
        for (int g = 0; g < 20; g++) begin
          act_t a;
          for (int i = 0; i < GS; i++)
            a[i] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(1, 255));
          if (g % 5 == 0) a = '0;
          send(a, w);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
  endtask

  task automatic test_drain;
    int n;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (sb.size() !== 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain pending=%0d out_valid=%b want 0 0", sb.size(), out_valid);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sparse();
    test_dense();
    test_zero_then_next();
    test_seventeen();
    test_back_to_back();
    test_reset_mid_split();
    test_random();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/znz_split_issue.md
Name: znz_split_issue

Overview:
Upstream issue stage for the per-group zero-skip compactor. Accepts one raw activation group per handshake and derives its zero/non-zero bitmap. Issues the group as one or more beats, each with at most GROUP_NZ_BITS bits set in the bitmap, so the downstream compactor never overflows its GROUP_NZ_BITS output slots. Sits between the activation buffer read port and the compactor's znz_din/act_din inputs.

Parameters:
GROUP_SIZE, 32, activations per group; also the bitmap width.
GROUP_NZ_BITS, 16, maximum non-zeros per issued beat; must equal the compactor's output slot count.
DATA_W, 8, activation width in bits.
CNT_W, $clog2(GROUP_SIZE+1), width of the non-zero count field.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  raw group valid
in_ready  out  1  raw group accepted when in_valid && in_ready
in_act  in  [GROUP_SIZE][DATA_W]  raw activation group
out_valid  out  1  beat valid
out_ready  in  1  beat consumed when out_valid && out_ready
out_znz  out  GROUP_SIZE  bitmap for this beat; bit i set = act i issued in this beat
out_act  out  [GROUP_SIZE][DATA_W]  latched group, unmodified, held for all beats of the group
out_nz_cnt  out  CNT_W  popcount(out_znz)
out_first  out  1  first beat of the group
out_last  out  1  final beat of the group

Behaviour:
- Non-zero test: element i is non-zero iff in_act[i] != 0 across all DATA_W bits.
- Registers: act_q (group), rem_q (bitmap of non-zeros not yet issued), first_q, out_valid_q.
- States: EMPTY (out_valid=0) and ISSUE (out_valid=1). No other states.
- in_ready = !rst && (!out_valid || (out_ready && out_last)). Combinational; allows back-to-back groups with no bubble.
- Accept (in_valid && in_ready):
  - act_q <= in_act; rem_q <= nonzero bitmap; first_q <= 1; out_valid <= 1.
  - Latency: 1 cycle from accept to out_valid.
- Beat formation (combinational from rem_q):
  - out_znz = the lowest-indexed min(popcount(rem_q), GROUP_NZ_BITS) set bits of rem_q, selected in ascending index order.
  - out_nz_cnt = popcount(out_znz).
  - out_last = (rem_q & ~out_znz) == 0.
  - out_first = first_q.
- Beat handshake, not last: rem_q <= rem_q & ~out_znz; first_q <= 0.
- Beat handshake, last: if a new group is accepted in the same cycle, load it as above; otherwise out_valid <= 0.
- All-zero group: exactly one beat with out_znz=0, out_nz_cnt=0, out_first=1, out_last=1. This preserves group alignment downstream.
- Beat count per group: max(1, ceil(k/GROUP_NZ_BITS)) for k non-zeros. Throughput is 1 beat/cycle when out_ready=1.
- Stability: while out_valid && !out_ready, all out_* signals hold constant. No input is accepted unless the held beat is the last one and is consumed that cycle.
- Reset:
  - On the next edge: out_valid=0, rem_q=0, first_q=0, act_q=0.
  - Derived outputs: out_znz=0, out_nz_cnt=0, out_last=1.
  - in_ready=0 while rst is high.
  - Reset mid-split discards the remaining beats; no partial beat is emitted after reset.
- Ordering across beats: beat n's set bits are all lower-indexed than beat n+1's.
- OR of all beats' out_znz equals the group's non-zero bitmap; beats are disjoint.

Test Plan:
1. Sparse group: in_act non-zero at indices 0, 3, 7, 20, 31, out_ready=1 -> one cycle after accept, one beat: out_znz=0x8010_0089, out_nz_cnt=5, out_first=1, out_last=1.
2. Dense group: all 32 elements non-zero -> beat 1: out_znz=0x0000_FFFF, cnt=16, first=1, last=0, in_ready=0; beat 2: out_znz=0xFFFF_0000, cnt=16, first=0, last=1, in_ready=1.
3. All-zero group -> single beat: out_znz=0, cnt=0, first=1, last=1. Next group accepted in the same cycle.
4. 17 non-zeros at bits 0..16 -> beats: 0x0000_FFFF (cnt 16) then 0x0001_0000 (cnt 1, last=1).
5. Backpressure and streaming:
   - out_ready=0 for 3 cycles during beat 1 of a dense group -> outputs stable, in_ready=0.
   - Then 4 sparse groups with in_valid=1 and out_ready=1 -> 4 beats in 4 consecutive cycles, no bubble.
6. rst=1 for one cycle after beat 1 of a dense group -> next cycle out_valid=0. Beat 2 is never emitted. After reset a new group issues normally with out_first=1.
